// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder-buffer commit (retire) side.
// The head-pointer width and depth here are the default configuration.
package rob_pkg;

    localparam int ROB_PTRWIDTH = 5;
    localparam int ROB_DEPTH    = 2 ** ROB_PTRWIDTH;

    typedef logic [ROB_PTRWIDTH-1:0] rob_ptr_t;

    typedef enum logic {
        OB_EMPTY = 1'b0,
        OB_FULL  = 1'b1
    } ob_state_t;

    // Clear mask selecting exactly the entry at ptr.
    function automatic logic [ROB_DEPTH-1:0] onehot_ptr(input rob_ptr_t ptr);
        return ROB_DEPTH'(1) << ptr;
    endfunction

endpackage

// File: rtl/rob_CommitOutReg.sv
// One-entry registered val/rdy output buffer for the commit unit.
// Flush empties the buffer but leaves the last message/index visible.
module rob_CommitOutReg
    import rob_pkg::*;
#(
    parameter int p_ptrwidth = 5,
    parameter int p_bitwidth = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  flush,
    input  logic [p_bitwidth-1:0] load_msg,
    input  logic [p_ptrwidth-1:0] load_idx,
    input  logic                  deq_rdy,
    output logic                  fire,
    output logic                  deq_val,
    output logic [p_bitwidth-1:0] deq_msg,
    output logic [p_ptrwidth-1:0] deq_idx
);

    ob_state_t             state_reg;
    logic [p_bitwidth-1:0] msg_reg;
    logic [p_ptrwidth-1:0] idx_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= OB_EMPTY;
            msg_reg   <= '0;
            idx_reg   <= '0;
        end else if (flush) begin
            state_reg <= OB_EMPTY;
        end else if (load) begin
            state_reg <= OB_FULL;
            msg_reg   <= load_msg;
            idx_reg   <= load_idx;
        end else if (fire) begin
            state_reg <= OB_EMPTY;
        end
    end

    // A load in the same cycle as a fire refills the buffer without a bubble.
    assign deq_val = (state_reg == OB_FULL);
    assign fire    = deq_val & deq_rdy;
    assign deq_msg = msg_reg;
    assign deq_idx = idx_reg;

endmodule

// File: rtl/rob_commit_unit.sv
// In-order retire side of the reorder buffer: reads the head entry once it is
// occupied, clears its occupied bit, and presents it on a val/rdy port.
module rob_commit_unit
    import rob_pkg::*;
#(
    parameter int p_ptrwidth = 5,
    parameter int p_bitwidth = 32,
    localparam int p_depth   = 2 ** p_ptrwidth
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [p_depth-1:0]            occ,
    input  logic [p_depth*p_bitwidth-1:0] data_in,
    output logic [p_depth-1:0]            clr_occ,
    output logic                          deq_val,
    input  logic                          deq_rdy,
    output logic [p_bitwidth-1:0]         deq_msg,
    output logic [p_ptrwidth-1:0]         deq_idx,
    input  logic                          flush,
    input  logic [p_ptrwidth-1:0]         flush_ptr,
    output logic [p_ptrwidth-1:0]         head_ptr
);

    logic [p_ptrwidth-1:0] head_reg;
    logic [p_depth-1:0]    head_mask;
    logic [p_bitwidth-1:0] entry_data [p_depth];
    logic                  fire;
    logic                  can_load;

    generate
        for (genvar gi = 0; gi < p_depth; gi++) begin : g_entry
            localparam logic [p_ptrwidth-1:0] ENTRY_IDX = p_ptrwidth'(gi);
            assign head_mask[gi]  = (head_reg == ENTRY_IDX);
            assign entry_data[gi] = data_in[gi*p_bitwidth +: p_bitwidth];
        end
    endgenerate

    // Loading needs the buffer free (or draining this cycle) and the head entry
    // filled; a flush overrides any load in the same cycle.
    assign can_load = (~deq_val | fire) & occ[head_reg] & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg <= '0;
        end else if (flush) begin
            head_reg <= flush_ptr;
        end else if (can_load) begin
            head_reg <= head_reg + 1'b1;
        end
    end

    // Reset gates the strobe so nothing is cleared while the unit is held in reset.
    always_comb begin
        clr_occ = '0;
        if (rst) begin
            if (flush) begin
                clr_occ = '1;
            end else if (can_load) begin
                clr_occ = head_mask;
            end
        end
    end

    rob_CommitOutReg #(
        .p_ptrwidth(p_ptrwidth),
        .p_bitwidth(p_bitwidth)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (can_load),
        .flush   (flush),
        .load_msg(entry_data[head_reg]),
        .load_idx(head_reg),
        .deq_rdy (deq_rdy),
        .fire    (fire),
        .deq_val (deq_val),
        .deq_msg (deq_msg),
        .deq_idx (deq_idx)
    );

    assign head_ptr = head_reg;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: directed vector tables, hand-written reset
// sequences, and a randomized run against a cycle-level reference model.
module tb_rob_commit_unit;
    import rob_pkg::*;

    localparam int PW = 5;
    localparam int BW = 32;
    localparam int DEPTH = 32;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [DEPTH-1:0]      occ = '0;
    logic [DEPTH*BW-1:0]   data_in = '0;
    logic [DEPTH-1:0]      clr_occ;
    logic                  deq_val;
    logic                  deq_rdy = 1'b0;
    logic [BW-1:0]         deq_msg;
    logic [PW-1:0]         deq_idx;
    logic                  flush = 1'b0;
    logic [PW-1:0]         flush_ptr = '0;
    logic [PW-1:0]         head_ptr;

    rob_commit_unit #(.p_ptrwidth(PW), .p_bitwidth(BW)) dut (
        .clk      (clk),
        .rst      (rst),
        .occ      (occ),
        .data_in  (data_in),
        .clr_occ  (clr_occ),
        .deq_val  (deq_val),
        .deq_rdy  (deq_rdy),
        .deq_msg  (deq_msg),
        .deq_idx  (deq_idx),
        .flush    (flush),
        .flush_ptr(flush_ptr),
        .head_ptr (head_ptr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    typedef struct {
        logic [31:0] occ;
        logic        rdy;
        logic        flush;
        logic [4:0]  fptr;
        logic        val;
        logic [4:0]  idx;
        logic [31:0] msg;
        logic [4:0]  head;
        logic [31:0] clr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [31:0] o, logic r, logic f, logic [4:0] fp,
                                logic v, logic [4:0] i, logic [31:0] m,
                                logic [4:0] h, logic [31:0] c);
        vec_t t;
        t.occ = o; t.rdy = r; t.flush = f; t.fptr = fp;
        t.val = v; t.idx = i; t.msg = m; t.head = h; t.clr = c;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs are applied just after a rising edge; outputs are checked on the falling edge.
    task automatic apply_row(input string tag, input vec_t t);
        occ = t.occ; deq_rdy = t.rdy; flush = t.flush; flush_ptr = t.fptr;
        @(negedge clk);
        $display("[TB] %s occ=%08h rdy=%0b flush=%0b -> val=%0b idx=%0d msg=%08h head=%0d clr=%08h",
                 tag, t.occ, t.rdy, t.flush, deq_val, deq_idx, deq_msg, head_ptr, clr_occ);
        check({tag, " deq_val"}, 64'(deq_val), 64'(t.val));
        check({tag, " deq_idx"}, 64'(deq_idx), 64'(t.idx));
        check({tag, " deq_msg"}, 64'(deq_msg), 64'(t.msg));
        check({tag, " head_ptr"}, 64'(head_ptr), 64'(t.head));
        check({tag, " clr_occ"}, 64'(clr_occ), 64'(t.clr));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, " deq_val"}, 64'(deq_val), 64'(0));
        check({tag, " head_ptr"}, 64'(head_ptr), 64'(0));
        check({tag, " deq_msg"}, 64'(deq_msg), 64'(0));
        check({tag, " deq_idx"}, 64'(deq_idx), 64'(0));
        check({tag, " clr_occ"}, 64'(clr_occ), 64'(0));
    endtask

    // Reference model state for the random phase
    int          m_head;
    bit          m_full;
    logic [31:0] m_msg;
    int          m_idx;
    logic [31:0] mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) data_in[i*BW +: BW] = 32'hA0 + 32'(i);

        // Reset asserted with every entry occupied: nothing may be cleared.
        occ = '1;
        #1 rst = 1'b0;
        #1 reset_checks("reset");
        occ = '0;
        @(posedge clk); #1;
        rst = 1'b1;

        // Idle, in-order dequeue, stall, ordering
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(32'h7, 1, 0, 0, 0, 0, 32'h00, 0, 32'h1));
        tbl.push_back(mk(32'h6, 1, 0, 0, 1, 0, 32'hA0, 1, 32'h2));
        tbl.push_back(mk(32'h4, 1, 0, 0, 1, 1, 32'hA1, 2, 32'h4));
        tbl.push_back(mk(32'h0, 1, 0, 0, 1, 2, 32'hA2, 3, 32'h0));
        tbl.push_back(mk(32'h0, 1, 0, 0, 0, 2, 32'hA2, 3, 32'h0));
        tbl.push_back(mk(32'h0, 0, 1, 0, 0, 2, 32'hA2, 3, 32'hFFFF_FFFF));
        tbl.push_back(mk(32'h3, 0, 0, 0, 0, 2, 32'hA2, 0, 32'h1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(32'h2, 0, 0, 0, 1, 0, 32'hA0, 1, 32'h0));
        tbl.push_back(mk(32'h2, 1, 0, 0, 1, 0, 32'hA0, 1, 32'h2));
        tbl.push_back(mk(32'h0, 1, 0, 0, 1, 1, 32'hA1, 2, 32'h0));
        tbl.push_back(mk(32'h0, 1, 0, 0, 0, 1, 32'hA1, 2, 32'h0));
        tbl.push_back(mk(32'h8, 1, 0, 0, 0, 1, 32'hA1, 2, 32'h0));
        tbl.push_back(mk(32'h8, 1, 0, 0, 0, 1, 32'hA1, 2, 32'h0));
        tbl.push_back(mk(32'hC, 1, 0, 0, 0, 1, 32'hA1, 2, 32'h4));
        tbl.push_back(mk(32'h8, 1, 0, 0, 1, 2, 32'hA2, 3, 32'h8));
        tbl.push_back(mk(32'h0, 1, 0, 0, 1, 3, 32'hA3, 4, 32'h0));
        tbl.push_back(mk(32'h0, 1, 0, 0, 0, 3, 32'hA3, 4, 32'h0));
        foreach (tbl[i]) apply_row($sformatf("vec%0d", i), tbl[i]);

        // Wrap from entry 31 to entry 0
        apply_row("wrap0", mk(32'h0, 1, 1, 31, 0, 3, 32'hA3, 4, 32'hFFFF_FFFF));
        apply_row("wrap1", mk(32'h8000_0001, 1, 0, 0, 0, 3, 32'hA3, 31, 32'h8000_0000));
        apply_row("wrap2", mk(32'h1, 1, 0, 0, 1, 31, 32'hBF, 0, 32'h1));
        apply_row("wrap3", mk(32'h0, 0, 0, 0, 1, 0, 32'hA0, 1, 32'h0));

        // Flush coinciding with a fire, then resume from flush_ptr
        apply_row("flush0", mk(32'h0, 1, 1, 7, 1, 0, 32'hA0, 1, 32'hFFFF_FFFF));
        apply_row("flush1", mk(32'h0, 1, 0, 0, 0, 0, 32'hA0, 7, 32'h0));
        apply_row("flush2", mk(32'h80, 1, 0, 0, 0, 0, 32'hA0, 7, 32'h80));
        apply_row("flush3", mk(32'h0, 0, 0, 0, 1, 7, 32'hA7, 8, 32'h0));

        // Asynchronous reset between edges while the buffer is full
        occ = 32'h100;
        #2 rst = 1'b0;
        #1 reset_checks("midreset");
        @(posedge clk); #1;
        rst = 1'b1;
        occ = '0;

        // Randomized run against the reference model
        m_head = 0; m_full = 0; m_msg = '0; m_idx = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            data_in[i*BW +: BW] = mem[i];
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic        fire_m;
            logic        can_m;
            logic [31:0] exp_clr;
            for (int k = 0; k < 3; k++) begin
                int e;
                e = int'($urandom_range(0, DEPTH-1));
                if (!occ[e] && ($urandom % 2 == 0)) begin
                    mem[e] = $urandom;
                    data_in[e*BW +: BW] = mem[e];
                    occ[e] = 1'b1;
                end
            end
            deq_rdy   = ($urandom % 4) != 0;
            flush     = ($urandom % 30) == 0;
            flush_ptr = PW'($urandom);

            fire_m  = m_full && deq_rdy;
            can_m   = (!m_full || fire_m) && occ[m_head] && !flush;
            exp_clr = flush ? '1 : (can_m ? onehot_ptr(rob_ptr_t'(m_head)) : '0);

            @(negedge clk);
            check($sformatf("rnd%0d deq_val", cyc), 64'(deq_val), 64'(m_full));
            check($sformatf("rnd%0d deq_idx", cyc), 64'(deq_idx), 64'(m_idx));
            check($sformatf("rnd%0d deq_msg", cyc), 64'(deq_msg), 64'(m_msg));
            check($sformatf("rnd%0d head_ptr", cyc), 64'(head_ptr), 64'(m_head));
            check($sformatf("rnd%0d clr_occ", cyc), 64'(clr_occ), 64'(exp_clr));
            if (fire_m) $display("[TB] rnd%0d dequeue idx=%0d msg=%08h", cyc, m_idx, m_msg);

            if (flush) begin
                m_full = 0;
                m_head = int'(flush_ptr);
            end else if (can_m) begin
                m_full = 1;
                m_msg  = mem[m_head];
                m_idx  = m_head;
                m_head = (m_head + 1) % DEPTH;
            end else if (fire_m) begin
                m_full = 0;
            end

            @(posedge clk); #1;
            occ = occ & ~exp_clr;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
In-order read/retire side of the reorder buffer. It watches the occupied bits of the p_depth storage entries, reads the entry at the head pointer once it is occupied, and presents it on a registered val/rdy dequeue port. In the same cycle it pulses that entry's clr_occ and advances the head. It is the consumer counterpart of the per-entry occupancy registers that the allocate/write side fills.

Parameters:
p_ptrwidth, 5, head pointer width; p_depth = 2**p_ptrwidth (derived localparam, 32 by default)
p_bitwidth, 32, payload width of one entry

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  asynchronous, active-low reset (asserted when 0)
occ  input  p_depth  occupied bit of each entry
data_in  input  p_depth*p_bitwidth  entry payloads flattened; entry i at [i*p_bitwidth +: p_bitwidth]
clr_occ  output  p_depth  per-entry occupied-clear strobe (combinational)
deq_val  output  1  dequeue valid (registered)
deq_rdy  input  1  consumer ready
deq_msg  output  p_bitwidth  dequeued payload (registered)
deq_idx  output  p_ptrwidth  entry index the payload came from (registered)
flush  input  1  discard everything in flight
flush_ptr  input  p_ptrwidth  new head pointer applied on flush
head_ptr  output  p_ptrwidth  current head pointer (registered)

Behaviour:
- State:
  - head register.
  - One-entry output buffer: deq_val/deq_msg/deq_idx, with states EMPTY (deq_val=0) and FULL (deq_val=1).
- Reset (rst=0, asynchronous):
  - head_ptr=0, deq_val=0, deq_msg=0, deq_idx=0.
  - clr_occ=0 while rst=0.
- fire = deq_val & deq_rdy. The transfer occurs in that cycle.
- can_load = (~deq_val | fire) & occ[head] & ~flush.
- When can_load is 1:
  - clr_occ = one-hot(head), combinationally in the same cycle.
  - Next edge: deq_msg <= data_in[head], deq_idx <= head, deq_val <= 1, head <= head+1 (mod p_depth).
- When fire is 1 and can_load is 0: deq_val <= 0 on the next edge.
- If the buffer is FULL and deq_rdy=0, deq_msg and deq_idx hold stable.
- Latency:
  - An entry whose occ rises at edge N is visible on deq_val from edge N+1, provided the buffer is EMPTY or firing.
  - Back-to-back occupied entries dequeue at 1 per cycle while deq_rdy=1.
- Ordering: strictly by head index. A later occupied entry is never dequeued while the head entry is unoccupied.
- Wrap: head p_depth-1 increments to 0, with no extra cycle.
- Flush (has priority over load):
  - clr_occ = all ones for that cycle.
  - Next edge: deq_val <= 0, head <= flush_ptr. deq_msg and deq_idx keep their old values.
  - If fire and flush occur in the same cycle, the fire counts as a completed transfer; the buffer is then emptied.
  - The cycle after flush resumes normal loading from flush_ptr.
- Entry-write conflict: the occupancy register gives write priority over clear. The allocator must not write the head entry while it is occupied. clr_occ only ever targets an occupied head (except during flush), so no check is done here.
- clr_occ is at most one-hot outside flush.
- Asynchronous reset mid-transfer drops any buffered entry immediately; the deq_val fall is visible without a clock edge.

Decomposition:
- rob_pkg holds:
  - typedef rob_ptr_t (logic [p_ptrwidth-1:0]);
  - the buffer state enum {OB_EMPTY, OB_FULL};
  - a function onehot_ptr(ptr) returning the p_depth-bit clear mask.
- One sub-module, rob_CommitOutReg: the val/rdy output buffer (load, fire, flush inputs; msg/idx storage).
- Head pointer and clr_occ logic live in rob_commit_unit.

Test Plan:
1. Reset, then occ=0 for 5 cycles -> deq_val=0, clr_occ=0, head_ptr=0 throughout.
2. occ[0..2]=1, data_in[i]=0xA0+i, deq_rdy=1:
   - clr_occ=0x1, 0x2, 0x4 on consecutive cycles.
   - deq_msg=0xA0, 0xA1, 0xA2 with deq_idx=0, 1, 2 on the following cycles.
   - head_ptr ends at 3.
3. occ[0],occ[1]=1, deq_rdy=0 for 4 cycles:
   - deq_val=1 and deq_msg=data[0] held.
   - Only clr_occ[0] pulses.
   - On deq_rdy=1, data[1] appears on the next cycle.
4. occ[0]=0, occ[1]=1 -> deq_val stays 0 and clr_occ=0 until occ[0] rises; then entry 0 dequeues before entry 1.
5. Head at 31, occ[31] and occ[0] set, deq_rdy=1 -> deq_idx=31 then 0 on consecutive cycles; head_ptr=1.
6. Buffer FULL, flush=1 with flush_ptr=7 and deq_rdy=1 in the same cycle:
   - Transfer counted; clr_occ=all ones that cycle.
   - Next cycle deq_val=0 and head_ptr=7.
   - Pulsing rst=0 mid-stream immediately zeroes deq_val and head_ptr.
